// File: rtl/rv32_writeback.sv
// rv32_writeback: the block that writes results into the RV32 integer register file.
//
// It merges single-cycle ALU results with load data that returns after a variable delay.
// Load data is aligned and sign- or zero-extended before it is written. The block also
// keeps a pending-load scoreboard, which decode uses to detect hazards against writes
// that are still in flight.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_alu_*, o_alu_ready           ALU result valid/ready handshake
//   i_ld_issue*, o_ld_issue_ready  load issue handshake; an accepted issue marks rd pending
//   i_ld_*                         load return (always accepted): rd, raw word, funct3, addr[1:0]
//   i_raddr1/2, o_hazard           decode read addresses and the combined hazard flag
//   o_write, o_waddr, o_wdata      registered register file write port
//   o_err                          sticky error: unexpected return or bad funct3
module rv32_writeback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_alu_valid,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    output logic        o_alu_ready,
    input  logic        i_ld_issue,
    input  logic [4:0]  i_ld_issue_rd,
    output logic        o_ld_issue_ready,
    input  logic        i_ld_valid,
    input  logic [4:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [4:0]  i_raddr1,
    input  logic [4:0]  i_raddr2,
    output logic        o_hazard,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata,
    output logic        o_write,
    output logic        o_err
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]       sb_q, sb_d;
    logic [4:0]        fifo_rd_q   [FIFO_DEPTH];
    logic [4:0]        fifo_rd_d   [FIFO_DEPTH];
    logic [31:0]       fifo_data_q [FIFO_DEPTH];
    logic [31:0]       fifo_data_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_q, fifo_vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              write_q, write_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic        fifo_full, fifo_empty, alu_acc, enq, deq;
    logic [31:0] pend_mask;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_wdata;
    logic        ld_fmt_err;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);

    // Every destination with a write still to come: a pending load, a queued ALU
    // result, or the write on the port this cycle.
    always_comb begin
        pend_mask = sb_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld_q[i]) pend_mask[fifo_rd_q[i]] = 1'b1;
        end
        if (write_q) pend_mask[waddr_q] = 1'b1;
    end

    assign o_alu_ready      = !fifo_full && ((i_alu_rd == 5'd0) || !sb_q[i_alu_rd]);
    assign o_ld_issue_ready = (i_ld_issue_rd == 5'd0) || !pend_mask[i_ld_issue_rd];
    assign o_hazard         = ((i_raddr1 != 5'd0) && pend_mask[i_raddr1]) ||
                              ((i_raddr2 != 5'd0) && pend_mask[i_raddr2]);
    assign alu_acc          = i_alu_valid && o_alu_ready;

    // Load alignment and extension
    always_comb begin
        ld_byte    = i_ld_data[{i_ld_addr_lo, 3'b000} +: 8];
        ld_half    = i_ld_addr_lo[1] ? i_ld_data[31:16] : i_ld_data[15:0];
        ld_fmt_err = 1'b0;
        case (i_ld_funct3)
            3'b000:  ld_wdata = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_wdata = {24'd0, ld_byte};
            3'b001:  ld_wdata = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_wdata = {16'd0, ld_half};
            3'b010:  ld_wdata = i_ld_data;
            default: begin
                ld_wdata   = 32'd0;
                ld_fmt_err = 1'b1;
            end
        endcase
    end

    // Write-port arbitration: load return, then FIFO head, then ALU bypass.
    // An ALU result that is accepted but loses arbitration is queued.
    always_comb begin
        sb_d        = sb_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        fifo_vld_d  = fifo_vld_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        write_d     = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        deq         = 1'b0;
        enq         = alu_acc && (i_ld_valid || !fifo_empty);

        if (i_ld_valid) begin
            write_d = (i_ld_rd != 5'd0);
            waddr_d = i_ld_rd;
            wdata_d = ld_wdata;
            // Any return for a nonzero rd whose bit is clear was never issued.
            if (ld_fmt_err || ((i_ld_rd != 5'd0) && !sb_q[i_ld_rd])) err_d = 1'b1;
            sb_d[i_ld_rd] = 1'b0;
        end else if (!fifo_empty) begin
            deq     = 1'b1;
            write_d = (fifo_rd_q[rd_ptr_q] != 5'd0);
            waddr_d = fifo_rd_q[rd_ptr_q];
            wdata_d = fifo_data_q[rd_ptr_q];
            fifo_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else if (alu_acc) begin
            write_d = (i_alu_rd != 5'd0);
            waddr_d = i_alu_rd;
            wdata_d = i_alu_data;
        end

        if (enq) begin
            fifo_rd_d[wr_ptr_q]   = i_alu_rd;
            fifo_data_d[wr_ptr_q] = i_alu_data;
            fifo_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        // The set is applied after the return clear. An issue and a return that
        // both target the same rd therefore leave that rd pending.
        if (i_ld_issue && o_ld_issue_ready && (i_ld_issue_rd != 5'd0)) begin
            sb_d[i_ld_issue_rd] = 1'b1;
        end

        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sb_q       <= '0;
            fifo_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            write_q    <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            sb_q        <= sb_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            fifo_vld_q  <= fifo_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            write_q     <= write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

    assign o_write = write_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;
    assign o_err   = err_q;
endmodule

// File: tb/tb_rv32_writeback.sv
module tb_rv32_writeback;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_issue_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [4:0]  raddr1, raddr2;
    logic        hazard;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        write;
    logic        err;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    rv32_writeback #(.FIFO_DEPTH(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data),
        .o_alu_ready(alu_ready),
        .i_ld_issue(ld_issue), .i_ld_issue_rd(ld_issue_rd), .o_ld_issue_ready(ld_issue_ready),
        .i_ld_valid(ld_valid), .i_ld_rd(ld_rd), .i_ld_data(ld_data),
        .i_ld_funct3(ld_funct3), .i_ld_addr_lo(ld_addr_lo),
        .i_raddr1(raddr1), .i_raddr2(raddr2), .o_hazard(hazard),
        .o_waddr(waddr), .o_wdata(wdata), .o_write(write), .o_err(err)
    );

    // Monitor: every register file write must match the next expected write.
    always @(negedge clk) begin
        if (write) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got x%0d=%08h, none expected", waddr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (waddr !== e.rd || wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL write_order: got x%0d=%08h, expected x%0d=%08h",
                             waddr, wdata, e.rd, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.rd = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [4:0] rd);
        ld_issue = 1'b1;
        ld_issue_rd = rd;
        #1;
        chk("issue_ready", ld_issue_ready, 1);
        step();
        ld_issue = 1'b0;
    endtask

    task automatic ret(input logic [4:0] rd, input logic [2:0] f3,
                       input logic [31:0] d, input logic [1:0] lo);
        ld_valid = 1'b1;
        ld_rd = rd;
        ld_funct3 = f3;
        ld_data = d;
        ld_addr_lo = lo;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd = rd;
        alu_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_issue = 0; ld_issue_rd = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; ld_funct3 = 0; ld_addr_lo = 0;
        raddr1 = 0; raddr2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write", write, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        // ALU bypass with an empty FIFO
        alu(5, 32'h1234);
        push(5, 32'h1234);
        #1;
        chk("alu_ready_idle", alu_ready, 1);
        step();
        alu_valid = 0;
        chk("bypass_write", write, 1);
        chk("bypass_waddr", waddr, 5);
        chk("bypass_wdata", wdata, 32'h1234);
        step();
        chk("bypass_one_cycle", write, 0);

        // LB with sign extension, and the hazard window
        issue(7);
        raddr1 = 7;
        #1;
        chk("haz_pending", hazard, 1);
        step();
        step();
        ret(7, 3'b000, 32'h0000_8000, 2'd1);
        push(7, 32'hFFFF_FF80);
        step();
        ld_valid = 0;
        chk("lb_write", write, 1);
        chk("lb_wdata", wdata, 32'hFFFF_FF80);
        chk("haz_write_cycle", hazard, 1);
        step();
        chk("haz_cleared", hazard, 0);
        raddr1 = 0;

        // Load return beats a simultaneous ALU result (LHU, upper half)
        issue(4);
        alu(3, 32'h33);
        ret(4, 3'b101, 32'hBEEF_0000, 2'd2);
        push(4, 32'h0000_BEEF);
        push(3, 32'h33);
        #1;
        chk("alu_ready_ld", alu_ready, 1);
        step();
        alu_valid = 0; ld_valid = 0;
        chk("lhu_waddr", waddr, 4);
        chk("lhu_wdata", wdata, 32'h0000_BEEF);
        step();
        chk("queued_alu_write", write, 1);
        chk("queued_alu_waddr", waddr, 3);
        step();

        // Three back-to-back returns with ALU traffic: FIFO fills, then drains in order
        for (int i = 0; i < 3; i++) issue(5'(10 + i));
        for (int i = 0; i < 3; i++) push(5'(10 + i), 32'hA0 + 32'(i));
        for (int i = 0; i < 3; i++) push(5'(20 + i), 32'h200 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            ret(5'(10 + i), 3'b010, 32'hA0 + 32'(i), 2'd0);
            alu(5'(20 + i), 32'h200 + 32'(i));
            #1;
            chk("fill_ready", alu_ready, (i < 2) ? 1 : 0);
            if (i < 2) step();
        end
        step();
        ld_valid = 0;
        k = 0;
        while (k < 8 && !alu_ready) begin
            step();
            k++;
        end
        chk("drain_ready_cycles", k, 1);
        step();
        alu_valid = 0;
        repeat (3) step();
        chk("err_clean", err, 0);

        // ALU blocked by a pending load; issue blocked by a queued rd
        issue(9);
        alu(9, 32'h9);
        #1;
        chk("alu_blocked_sb", alu_ready, 0);
        alu_valid = 0;
        issue(13);
        ret(13, 3'b010, 32'h13, 2'd0);
        alu(2, 32'h22);
        push(13, 32'h13);
        push(2, 32'h22);
        step();
        ld_valid = 0; alu_valid = 0;
        ld_issue = 1; ld_issue_rd = 2; raddr2 = 2;
        #1;
        chk("issue_blocked_fifo", ld_issue_ready, 0);
        chk("haz_fifo", hazard, 1);
        ld_issue = 0; raddr2 = 0;
        step();
        step();
        ret(9, 3'b010, 32'h99, 2'd0);
        push(9, 32'h99);
        step();
        ld_valid = 0;
        step();
        ret(0, 3'b010, 32'hDEAD_BEEF, 2'd0);
        step();
        ld_valid = 0;
        step();
        chk("rd0_no_write", write, 0);

        // Unissued return, then an illegal funct3
        ret(6, 3'b010, 32'h66, 2'd0);
        push(6, 32'h66);
        step();
        ld_valid = 0;
        step();
        chk("err_set", err, 1);
        issue(14);
        ret(14, 3'b011, 32'hFFFF_FFFF, 2'd0);
        push(14, 32'h0);
        step();
        ld_valid = 0;
        chk("badf3_wdata", wdata, 0);
        chk("badf3_waddr", waddr, 14);
        step();
        chk("err_sticky", err, 1);

        // Reset in the middle of a FIFO drain
        issue(15);
        issue(16);
        issue(19);
        push(15, 32'h15);
        push(16, 32'h16);
        push(17, 32'h17);
        ret(15, 3'b010, 32'h15, 2'd0);
        alu(17, 32'h17);
        step();
        ret(16, 3'b010, 32'h16, 2'd0);
        alu(18, 32'h18);
        step();
        ld_valid = 0; alu_valid = 0;
        step();
        chk("drain_waddr", waddr, 17);
        raddr1 = 18; raddr2 = 19;
        #1;
        chk("haz_pre_reset", hazard, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_write", write, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_hazard", hazard, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_hazard", hazard, 0);
        repeat (4) step();
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
